// File: rtl/rv_boot_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_boot_loader : serial boot sequencer, loads a framed image into IMEM
// Revision 1.0
// ----------------------------------------------------------------------------
module rv_boot_loader #(
    parameter int         AW      = 12,
    parameter int         TIMEOUT = 1000000,
    parameter logic [7:0] MAGIC   = 8'hA5
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          load_req,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          im_we,
    output logic          cpu_clrn,
    output logic          loading,
    output logic          done,
    output logic [1:0]    err
);

    localparam logic [2:0] S_HDR  = 3'd0;
    localparam logic [2:0] S_CNTL = 3'd1;
    localparam logic [2:0] S_CNTH = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_SUM  = 3'd4;
    localparam logic [2:0] S_RUN  = 3'd5;

    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [16:0]    MAX_WORDS = 17'(2 ** AW);

    logic [2:0]    state;
    logic [7:0]    cnt_lo;
    logic [16:0]   remaining;
    logic [AW-1:0] wr_addr;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic [7:0]    csum;
    logic [TW-1:0] tmo_cnt;

    logic          in_frame;
    logic          timeout;
    logic [15:0]   frame_count;
    logic [7:0]    csum_next;

    assign in_frame    = (state == S_CNTL) || (state == S_CNTH) ||
                         (state == S_DATA) || (state == S_SUM);
    // An arriving byte always beats an expiring timer.
    assign timeout     = in_frame && !rx_valid && (tmo_cnt == TMO_LAST);
    assign frame_count = {rx_data, cnt_lo};
    assign csum_next   = csum + rx_data;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= S_HDR;
            cnt_lo    <= '0;
            remaining <= '0;
            wr_addr   <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            csum      <= '0;
            tmo_cnt   <= '0;
            im_addr   <= '0;
            im_wdata  <= '0;
            im_we     <= 1'b0;
            cpu_clrn  <= 1'b0;
            loading   <= 1'b1;
            done      <= 1'b0;
            err       <= 2'd0;
        end else begin
            im_we <= 1'b0;
            done  <= 1'b0;

            if (rx_valid || !in_frame) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (timeout) begin
                err   <= 2'd2;
                state <= S_HDR;
            end else begin
                case (state)
                    S_HDR: begin
                        if (rx_valid && (rx_data == MAGIC)) begin
                            state    <= S_CNTL;
                            err      <= 2'd0;
                            csum     <= '0;
                            wr_addr  <= '0;
                            byte_idx <= '0;
                        end
                    end
                    S_CNTL: begin
                        if (rx_valid) begin
                            cnt_lo <= rx_data;
                            csum   <= csum_next;
                            state  <= S_CNTH;
                        end
                    end
                    S_CNTH: begin
                        if (rx_valid) begin
                            csum      <= csum_next;
                            remaining <= {1'b0, frame_count};
                            if ({1'b0, frame_count} > MAX_WORDS) begin
                                err   <= 2'd3;
                                state <= S_HDR;
                            end else if (frame_count == 16'd0) begin
                                state <= S_SUM;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_valid) begin
                            csum     <= csum_next;
                            byte_idx <= byte_idx + 2'd1;
                            case (byte_idx)
                                2'd0: word_buf[7:0]   <= rx_data;
                                2'd1: word_buf[15:8]  <= rx_data;
                                2'd2: word_buf[23:16] <= rx_data;
                                default: begin
                                    im_we     <= 1'b1;
                                    im_addr   <= wr_addr;
                                    im_wdata  <= {rx_data, word_buf};
                                    wr_addr   <= wr_addr + AW'(1);
                                    remaining <= remaining - 17'd1;
                                    if (remaining == 17'd1) begin
                                        state <= S_SUM;
                                    end
                                end
                            endcase
                        end
                    end
                    S_SUM: begin
                        if (rx_valid) begin
                            if (rx_data == csum) begin
                                done     <= 1'b1;
                                cpu_clrn <= 1'b1;
                                loading  <= 1'b0;
                                state    <= S_RUN;
                            end else begin
                                err   <= 2'd1;
                                state <= S_HDR;
                            end
                        end
                    end
                    S_RUN: begin
                        if (load_req) begin
                            cpu_clrn <= 1'b0;
                            loading  <= 1'b1;
                            state    <= S_HDR;
                        end
                    end
                    default: state <= S_HDR;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for rv_boot_loader: table of frames plus timing/reset corner sequences.
module tb_rv_boot_loader;

    localparam int AW  = 12;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          load_req = 1'b0;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          im_we;
    logic          cpu_clrn;
    logic          loading;
    logic          done;
    logic [1:0]    err;

    rv_boot_loader #(.AW(AW), .TIMEOUT(TMO), .MAGIC(8'hA5)) dut (
        .clk(clk), .clrn(clrn), .rx_data(rx_data), .rx_valid(rx_valid),
        .load_req(load_req), .im_addr(im_addr), .im_wdata(im_wdata),
        .im_we(im_we), .cpu_clrn(cpu_clrn), .loading(loading),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] b;
        int           len;
        bit           b2b;
        logic [1:0]   err;
        int           dones;
        bit           run;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  obs_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    bit   in_run = 1'b0;
    vec_t vt[6];

    always @(negedge clk) begin
        if (im_we) obs_q.push_back({im_addr, im_wdata});
        if (done) done_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input vec_t v, input int i);
        return v.b[8*(v.len-1-i) +: 8];
    endfunction

    // Independent frame parser: which words should land where.
    task automatic push_writes(input vec_t v);
        int m;
        int cnt;
        wr_t w;
        m = -1;
        for (int i = 0; i < v.len; i++)
            if (m < 0 && byte_of(v, i) == 8'hA5) m = i;
        if (m < 0 || m + 2 >= v.len) return;
        cnt = {16'd0, byte_of(v, m+2), byte_of(v, m+1)};
        if (cnt > (1 << AW)) return;
        for (int k = 0; k < cnt && (m + 3 + 4*k + 3) < v.len; k++) begin
            w.a = AW'(k);
            w.d = {byte_of(v, m+6+4*k), byte_of(v, m+5+4*k),
                   byte_of(v, m+4+4*k), byte_of(v, m+3+4*k)};
            exp_q.push_back(w);
        end
    endtask

    task automatic drain(input string nm);
        wr_t e;
        wr_t o;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({nm, " wr_addr"}, 32'(o.a), 32'(e.a));
            chk({nm, " wr_data"}, o.d, e.d);
        end
        chk({nm, " missing_writes"}, 32'(exp_q.size()), 32'd0);
        chk({nm, " extra_writes"}, 32'(obs_q.size()), 32'd0);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("load_req cpu_clrn", 32'(cpu_clrn), 32'd0);
        chk("load_req loading", 32'(loading), 32'd1);
        in_run = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        int base;
        if (in_run) pulse_load_req();
        push_writes(v);
        base = done_cnt;
        for (int i = 0; i < v.len; i++) send_byte(byte_of(v, i), !v.b2b);
        repeat (2) @(negedge clk);
        drain(nm);
        chk({nm, " err"}, 32'(err), 32'(v.err));
        chk({nm, " done_pulses"}, 32'(done_cnt - base), 32'(v.dones));
        chk({nm, " cpu_clrn"}, 32'(cpu_clrn), 32'(v.run));
        chk({nm, " loading"}, 32'(loading), 32'(!v.run));
        in_run = v.run;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " im_addr"}, 32'(im_addr), 32'd0);
        chk({nm, " im_wdata"}, im_wdata, 32'd0);
        chk({nm, " im_we"}, 32'(im_we), 32'd0);
        chk({nm, " cpu_clrn"}, 32'(cpu_clrn), 32'd0);
        chk({nm, " loading"}, 32'(loading), 32'd1);
        chk({nm, " done"}, 32'(done), 32'd0);
        chk({nm, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int base;
        vt[0] = '{b: 128'({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                           8'h93, 8'h00, 8'h10, 8'h00, 8'hB8}),
                  len: 12, b2b: 1'b0, err: 2'd0, dones: 1, run: 1'b1};
        vt[1] = '{b: 128'({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                           8'h93, 8'h00, 8'h10, 8'h00, 8'hB9}),
                  len: 12, b2b: 1'b0, err: 2'd1, dones: 0, run: 1'b0};
        vt[2] = '{b: 128'({8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                           8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB8}),
                  len: 14, b2b: 1'b1, err: 2'd0, dones: 1, run: 1'b1};
        vt[3] = '{b: 128'({8'hA5, 8'h00, 8'h00, 8'h00}),
                  len: 4, b2b: 1'b0, err: 2'd0, dones: 1, run: 1'b1};
        vt[4] = '{b: 128'({8'hA5, 8'h01, 8'h10}),
                  len: 3, b2b: 1'b0, err: 2'd3, dones: 0, run: 1'b0};
        vt[5] = '{b: 128'({8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h39}),
                  len: 8, b2b: 1'b1, err: 2'd0, dones: 1, run: 1'b1};

        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

        // Timeout: 100 idle cycles after a byte inside DATA aborts the frame.
        pulse_load_req();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        repeat (TMO - 1) @(negedge clk);
        chk("tmo before_limit err", 32'(err), 32'd0);
        @(negedge clk);
        chk("tmo at_limit err", 32'(err), 32'd2);
        chk("tmo cpu_clrn", 32'(cpu_clrn), 32'd0);
        drain("tmo");

        // A byte arriving on the limit cycle keeps the frame alive.
        base = done_cnt;
        exp_q.push_back({12'd0, 32'h0000_0013});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'h00, 1'b0);
        chk("tmo_rescue err", 32'(err), 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h14, 1'b0);
        repeat (2) @(negedge clk);
        drain("tmo_rescue");
        chk("tmo_rescue done", 32'(done_cnt - base), 32'd1);
        chk("tmo_rescue cpu_clrn", 32'(cpu_clrn), 32'd1);
        in_run = 1'b1;

        // load_req during DATA is ignored.
        pulse_load_req();
        base = done_cnt;
        exp_q.push_back({12'd0, 32'h4433_2211});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("ldreq_data loading", 32'(loading), 32'd1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'hAB, 1'b1);
        @(negedge clk);
        drain("ldreq_data");
        chk("ldreq_data done", 32'(done_cnt - base), 32'd1);
        chk("ldreq_data cpu_clrn", 32'(cpu_clrn), 32'd1);
        chk("ldreq_data err", 32'(err), 32'd0);
        in_run = 1'b1;

        // Asynchronous reset mid-DATA.
        pulse_load_req();
        exp_q.push_back({12'd0, 32'h4433_2211});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        chk("pre_reset im_wdata", im_wdata, 32'h4433_2211);
        clrn = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        drain("mid_reset");
        in_run = 1'b0;
        apply_vec(vt[0], "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached, required bench to finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
